integer_issue_tracker: RTL and testbench

INTEGER_ISSUE_TRACKER -- requirements
Module: integer_issue_tracker

---
 rtl/integer_issue_tracker_pkg.sv | 34 +++
 rtl/integer_issue_tracker_stage.sv | 53 +++++
 rtl/integer_issue_tracker.sv | 93 +++++++++
 tb/tb_integer_issue_tracker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/integer_issue_tracker_pkg.sv
// Shared control types for the integer issue tracker: instruction and unit types,
// width defaults and the retirement-stage classification.
package integer_issue_tracker_pkg;

    localparam int TIA_WORD_WIDTH        = 32;
    localparam int COUNTER_WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        FU_NOP    = 3'd0,
        FU_ALU    = 3'd1,
        FU_LSU    = 3'd2,
        FU_SM     = 3'd3,
        FU_IMU    = 3'd4,
        FU_BRANCH = 3'd5
    } functional_unit_t;

    typedef struct packed {
        logic [5:0]                opcode;
        logic [3:0]                dst;
        logic [3:0]                src0;
        logic [3:0]                src1;
        logic [TIA_WORD_WIDTH-1:0] immediate;
    } datapath_instruction_t;

    localparam logic [2:0] STAGE_NONE = 3'd0;
    localparam logic [2:0] STAGE_ONE  = 3'd1;
    localparam logic [2:0] STAGE_TWO  = 3'd2;

    // Shift/multiply units need the extra X2 cycle; everything else finishes in DX1.
    function automatic logic [2:0] retiring_stage_of(input functional_unit_t fu);
        return ((fu == FU_SM) || (fu == FU_IMU)) ? STAGE_TWO : STAGE_ONE;
    endfunction

endpackage

// File: rtl/integer_issue_tracker_stage.sv
// One pipeline stage slot (valid + instruction + unit) with hold and clear.
// Payload is zeroed whenever the slot is empty so outputs read 0 for bubbles.
module integer_stage_register
    import integer_issue_tracker_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  hold,
    input  logic                  valid_in,
    input  datapath_instruction_t instruction_in,
    input  functional_unit_t      unit_in,
    output logic                  valid,
    output datapath_instruction_t instruction,
    output functional_unit_t      unit
);

    logic                  valid_d, valid_q;
    datapath_instruction_t instruction_d, instruction_q;
    functional_unit_t      unit_d, unit_q;

    always_comb begin
        valid_d       = valid_q;
        instruction_d = instruction_q;
        unit_d        = unit_q;
        if (clear) begin
            valid_d       = 1'b0;
            instruction_d = '0;
            unit_d        = FU_NOP;
        end else if (!hold) begin
            valid_d       = valid_in;
            instruction_d = valid_in ? instruction_in : '0;
            unit_d        = valid_in ? unit_in : FU_NOP;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q       <= 1'b0;
            instruction_q <= '0;
            unit_q        <= FU_NOP;
        end else begin
            valid_q       <= valid_d;
            instruction_q <= instruction_d;
            unit_q        <= unit_d;
        end
    end

    assign valid       = valid_q;
    assign instruction = instruction_q;
    assign unit        = unit_q;

endmodule

// File: rtl/integer_issue_tracker.sv
// Two-stage (DX1/X2) integer retirement tracker: accepts issues, reports which
// stage retires each cycle and counts retired instructions.
module integer_issue_tracker
    import integer_issue_tracker_pkg::*;
#(
    parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  datapath_instruction_t    issue_datapath_instruction,
    input  functional_unit_t         issue_functional_unit,
    output logic                     issue_ready,
    input  logic                     stall,
    input  logic                     flush,
    output logic [2:0]               dx1_instruction_retiring_stage,
    output logic [2:0]               x2_instruction_retiring_stage,
    output datapath_instruction_t    dx1_datapath_instruction,
    output datapath_instruction_t    x2_datapath_instruction,
    output functional_unit_t         dx1_functional_unit,
    output functional_unit_t         x2_functional_unit,
    output logic                     pipeline_empty,
    output logic [COUNTER_WIDTH-1:0] retired_count
);

    logic                     dx1_valid, x2_valid;
    logic [2:0]               dx1_stage, issue_stage;
    logic                     issue_accept, dx1_to_x2;
    logic                     dx1_retiring, x2_retiring;
    logic [COUNTER_WIDTH-1:0] retired_count_d, retired_count_q;

    always_comb begin
        issue_stage = retiring_stage_of(issue_functional_unit);
        dx1_stage   = retiring_stage_of(dx1_functional_unit);

        // A stage-1 issue behind a stage-2 occupant would retire alongside it in X2.
        issue_ready = reset && !stall && !flush &&
                      !((issue_stage == STAGE_ONE) && dx1_valid && (dx1_stage == STAGE_TWO));
        issue_accept = issue_valid && issue_ready;
        dx1_to_x2    = dx1_valid && (dx1_stage == STAGE_TWO);

        dx1_retiring = dx1_valid && (dx1_stage == STAGE_ONE) && !stall;
        x2_retiring  = x2_valid && !stall;
        dx1_instruction_retiring_stage = dx1_retiring ? STAGE_ONE : STAGE_NONE;
        x2_instruction_retiring_stage  = x2_retiring  ? STAGE_TWO : STAGE_NONE;

        retired_count_d = retired_count_q;
        if (!flush && (dx1_retiring ^ x2_retiring)) begin
            retired_count_d = retired_count_q + COUNTER_WIDTH'(1);
        end
    end

    integer_stage_register u_dx1 (
        .clock          (clock),
        .reset          (reset),
        .clear          (flush),
        .hold           (stall),
        .valid_in       (issue_accept),
        .instruction_in (issue_datapath_instruction),
        .unit_in        (issue_functional_unit),
        .valid          (dx1_valid),
        .instruction    (dx1_datapath_instruction),
        .unit           (dx1_functional_unit)
    );

    integer_stage_register u_x2 (
        .clock          (clock),
        .reset          (reset),
        .clear          (flush),
        .hold           (stall),
        .valid_in       (dx1_to_x2),
        .instruction_in (dx1_datapath_instruction),
        .unit_in        (dx1_functional_unit),
        .valid          (x2_valid),
        .instruction    (x2_datapath_instruction),
        .unit           (x2_functional_unit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_count_q <= '0;
        end else begin
            retired_count_q <= retired_count_d;
        end
    end

    assign retired_count  = retired_count_q;
    assign pipeline_empty = !dx1_valid && !x2_valid;

    a_single_retirement: assert property (@(posedge clock) disable iff (!reset)
        !(dx1_retiring && x2_retiring));

endmodule

// File: tb/tb_integer_issue_tracker.sv
// Self-checking bench for integer_issue_tracker: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_integer_issue_tracker;
    import integer_issue_tracker_pkg::*;

    localparam int CW      = 6;
    localparam int CNT_MOD = 1 << CW;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  issue_valid = 1'b0;
    datapath_instruction_t issue_instr = '0;
    functional_unit_t      issue_fu = FU_NOP;
    logic                  stall = 1'b0;
    logic                  flush = 1'b0;

    logic                  issue_ready;
    logic [2:0]            dx1_ret, x2_ret;
    datapath_instruction_t dx1_instr, x2_instr;
    functional_unit_t      dx1_fu, x2_fu;
    logic                  pipeline_empty;
    logic [CW-1:0]         retired_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic                  m_dx1_v = 1'b0, m_x2_v = 1'b0;
    datapath_instruction_t m_dx1_i = '0, m_x2_i = '0;
    functional_unit_t      m_dx1_f = FU_NOP, m_x2_f = FU_NOP;
    int                    m_count = 0;

    integer_issue_tracker #(.COUNTER_WIDTH(CW)) dut (
        .clock                          (clock),
        .reset                          (reset),
        .issue_valid                    (issue_valid),
        .issue_datapath_instruction     (issue_instr),
        .issue_functional_unit          (issue_fu),
        .issue_ready                    (issue_ready),
        .stall                          (stall),
        .flush                          (flush),
        .dx1_instruction_retiring_stage (dx1_ret),
        .x2_instruction_retiring_stage  (x2_ret),
        .dx1_datapath_instruction       (dx1_instr),
        .x2_datapath_instruction        (x2_instr),
        .dx1_functional_unit            (dx1_fu),
        .x2_functional_unit             (x2_fu),
        .pipeline_empty                 (pipeline_empty),
        .retired_count                  (retired_count)
    );

    always #5 clock = ~clock;

    function automatic int ref_stage(input functional_unit_t f);
        return ((f == FU_SM) || (f == FU_IMU)) ? 2 : 1;
    endfunction

    function automatic logic ref_ready();
        return reset && !stall && !flush &&
               !(ref_stage(issue_fu) == 1 && m_dx1_v && ref_stage(m_dx1_f) == 2);
    endfunction

    function automatic int ref_dx1_ret();
        return (m_dx1_v && ref_stage(m_dx1_f) == 1 && !stall) ? 1 : 0;
    endfunction

    function automatic int ref_x2_ret();
        return (m_x2_v && !stall) ? 2 : 0;
    endfunction

    task automatic model_clear();
        m_dx1_v = 1'b0; m_dx1_i = '0; m_dx1_f = FU_NOP;
        m_x2_v  = 1'b0; m_x2_i  = '0; m_x2_f  = FU_NOP;
    endtask

    task automatic model_edge();
        int  n;
        logic acc;
        acc = issue_valid && ref_ready();
        if (!reset) begin
            model_clear();
            m_count = 0;
        end else if (flush) begin
            model_clear();
        end else if (!stall) begin
            n = 0;
            if (ref_dx1_ret() != 0) n++;
            if (ref_x2_ret() != 0) n++;
            if (n == 1) m_count = (m_count + 1) % CNT_MOD;
            if (m_dx1_v && ref_stage(m_dx1_f) == 2) begin
                m_x2_v = 1'b1; m_x2_i = m_dx1_i; m_x2_f = m_dx1_f;
            end else begin
                m_x2_v = 1'b0; m_x2_i = '0; m_x2_f = FU_NOP;
            end
            if (acc) begin
                m_dx1_v = 1'b1; m_dx1_i = issue_instr; m_dx1_f = issue_fu;
            end else begin
                m_dx1_v = 1'b0; m_dx1_i = '0; m_dx1_f = FU_NOP;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic v, input functional_unit_t f, input logic s, input logic fl);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        issue_valid = v;
        issue_fu    = f;
        issue_instr = r[$bits(datapath_instruction_t)-1:0];
        stall       = s;
        flush       = fl;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, FU_ALU, 1'b0, 1'b0);
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0b want 0", issue_ready); end
        n_checks++; if (pipeline_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b want 1", pipeline_empty); end
        n_checks++; if (retired_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", retired_count); end
        n_checks++; if (dx1_ret !== 3'd0 || x2_ret !== 3'd0) begin n_fail++; $display("FAIL reset_ret got %0d/%0d want 0/0", dx1_ret, x2_ret); end
        @(posedge clock);
        #2;
        reset = 1'b1;
        model_clear();
        m_count = 0;
        drive(1'b0, FU_NOP, 1'b0, 1'b0);
    endtask

    task automatic test_alu_pair();
        int c0;
        c0 = m_count;
        drive(1'b1, FU_ALU, 1'b0, 1'b0);
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready0 got %0b want 1", issue_ready); end
        tick();
        drive(1'b1, FU_ALU, 1'b0, 1'b0);
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready1 got %0b want 1", issue_ready); end
        n_checks++; if (dx1_ret !== 3'd1) begin n_fail++; $display("FAIL alu_dx1_a got %0d want 1", dx1_ret); end
        tick();
        drive(1'b0, FU_NOP, 1'b0, 1'b0);
        n_checks++; if (dx1_ret !== 3'd1) begin n_fail++; $display("FAIL alu_dx1_b got %0d want 1", dx1_ret); end
        tick();
        n_checks++; if (retired_count !== CW'((c0 + 2) % CNT_MOD)) begin n_fail++; $display("FAIL alu_count got %0d want %0d", retired_count, (c0 + 2) % CNT_MOD); end
        n_checks++; if (pipeline_empty !== 1'b1) begin n_fail++; $display("FAIL alu_empty got %0b want 1", pipeline_empty); end
    endtask

    task automatic test_imu_alu();
        drive(1'b1, FU_IMU, 1'b0, 1'b0);
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL imu_ready got %0b want 1", issue_ready); end
        tick();
        drive(1'b1, FU_ALU, 1'b0, 1'b0);
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL imu_alu_blocked got %0b want 0", issue_ready); end
        n_checks++; if (dx1_ret !== 3'd0 || x2_ret !== 3'd0) begin n_fail++; $display("FAIL imu_dx1_ret got %0d/%0d want 0/0", dx1_ret, x2_ret); end
        tick();
        issue_valid = 1'b1; #1;
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL imu_alu_accept got %0b want 1", issue_ready); end
        n_checks++; if (x2_ret !== 3'd2 || dx1_ret !== 3'd0) begin n_fail++; $display("FAIL imu_x2_ret got %0d/%0d want 0/2", dx1_ret, x2_ret); end
        tick();
        drive(1'b0, FU_NOP, 1'b0, 1'b0);
        n_checks++; if (dx1_ret !== 3'd1 || x2_ret !== 3'd0) begin n_fail++; $display("FAIL imu_then_alu got %0d/%0d want 1/0", dx1_ret, x2_ret); end
        tick();
    endtask

    task automatic test_back_to_back();
        int x2_cycles, both, acc;
        x2_cycles = 0; both = 0; acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(1'b1, FU_SM, 1'b0, 1'b0);
            else drive(1'b0, FU_NOP, 1'b0, 1'b0);
            if (i < 3 && issue_ready === 1'b1) acc++;
            if (x2_ret === 3'd2) x2_cycles++;
            if (x2_ret !== 3'd0 && dx1_ret !== 3'd0) both++;
            tick();
        end
        n_checks++; if (acc !== 3) begin n_fail++; $display("FAIL b2b_accepted got %0d want 3", acc); end
        n_checks++; if (x2_cycles !== 3) begin n_fail++; $display("FAIL b2b_x2_cycles got %0d want 3", x2_cycles); end
        n_checks++; if (both !== 0) begin n_fail++; $display("FAIL b2b_dual_retire got %0d want 0", both); end
    endtask

    task automatic test_stall();
        int c0;
        drive(1'b1, FU_IMU, 1'b0, 1'b0);
        tick();
        c0 = m_count;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, FU_SM, 1'b1, 1'b0);
            n_checks++; if (dx1_ret !== 3'd0 || x2_ret !== 3'd0 || issue_ready !== 1'b0) begin n_fail++; $display("FAIL stall_outputs got ret %0d/%0d ready %0b want 0/0 0", dx1_ret, x2_ret, issue_ready); end
            n_checks++; if (dx1_fu !== FU_IMU || retired_count !== CW'(c0)) begin n_fail++; $display("FAIL stall_hold got fu %0d cnt %0d want %0d %0d", dx1_fu, retired_count, FU_IMU, c0); end
            tick();
        end
        drive(1'b0, FU_NOP, 1'b0, 1'b0);
        n_checks++; if (x2_ret !== 3'd0 || dx1_fu !== FU_IMU) begin n_fail++; $display("FAIL stall_release got x2 %0d fu %0d want 0 %0d", x2_ret, dx1_fu, FU_IMU); end
        tick();
        n_checks++; if (x2_ret !== 3'd2 || x2_fu !== FU_IMU) begin n_fail++; $display("FAIL stall_x2_retire got %0d fu %0d want 2 %0d", x2_ret, x2_fu, FU_IMU); end
        tick();
        n_checks++; if (retired_count !== CW'((c0 + 1) % CNT_MOD)) begin n_fail++; $display("FAIL stall_count got %0d want %0d", retired_count, (c0 + 1) % CNT_MOD); end
    endtask

    task automatic test_flush();
        int c0;
        drive(1'b1, FU_IMU, 1'b0, 1'b0);
        tick();
        drive(1'b1, FU_SM, 1'b0, 1'b0);
        tick();
        drive(1'b1, FU_SM, 1'b1, 1'b1);
        c0 = m_count;
        n_checks++; if (issue_ready !== 1'b0 || pipeline_empty !== 1'b0) begin n_fail++; $display("FAIL flush_pre got ready %0b empty %0b want 0 0", issue_ready, pipeline_empty); end
        tick();
        drive(1'b0, FU_NOP, 1'b0, 1'b0);
        n_checks++; if (pipeline_empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty got %0b want 1", pipeline_empty); end
        n_checks++; if (retired_count !== CW'(c0)) begin n_fail++; $display("FAIL flush_count got %0d want %0d", retired_count, c0); end
        n_checks++; if (dx1_instr !== '0 || x2_fu !== FU_NOP) begin n_fail++; $display("FAIL flush_zero got %0h %0d want 0 0", dx1_instr, x2_fu); end
    endtask

    task automatic test_wrap();
        int guard;
        guard = 0;
        while (m_count != CNT_MOD - 1 && guard < 200) begin
            drive(1'b1, FU_ALU, 1'b0, 1'b0);
            tick();
            guard++;
        end
        n_checks++; if (guard >= 200) begin n_fail++; $display("FAIL wrap_timeout got %0d cycles want <200", guard); end
        drive(1'b0, FU_NOP, 1'b0, 1'b0);
        n_checks++; if (retired_count !== CW'(CNT_MOD - 1) || dx1_ret !== 3'd1) begin n_fail++; $display("FAIL wrap_pre got %0d ret %0d want %0d 1", retired_count, dx1_ret, CNT_MOD - 1); end
        tick();
        n_checks++; if (retired_count !== '0) begin n_fail++; $display("FAIL wrap_zero got %0d want 0", retired_count); end
    endtask

    task automatic test_random();
        functional_unit_t f;
        for (int i = 0; i < 1500; i++) begin
            f = functional_unit_t'(3'($urandom_range(0, 5)));
            drive(1'($urandom_range(0, 1)), f, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
            n_checks++; if (issue_ready !== ref_ready()) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", i, issue_ready, ref_ready()); end
            n_checks++; if (dx1_ret !== 3'(ref_dx1_ret()) || x2_ret !== 3'(ref_x2_ret())) begin n_fail++; $display("FAIL rnd_ret cyc %0d got %0d/%0d want %0d/%0d", i, dx1_ret, x2_ret, ref_dx1_ret(), ref_x2_ret()); end
            n_checks++; if (pipeline_empty !== (!m_dx1_v && !m_x2_v)) begin n_fail++; $display("FAIL rnd_empty cyc %0d got %0b", i, pipeline_empty); end
            n_checks++; if (retired_count !== CW'(m_count)) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, retired_count, m_count); end
            n_checks++; if (dx1_instr !== m_dx1_i || dx1_fu !== m_dx1_f) begin n_fail++; $display("FAIL rnd_dx1 cyc %0d got %0h/%0d want %0h/%0d", i, dx1_instr, dx1_fu, m_dx1_i, m_dx1_f); end
            n_checks++; if (x2_instr !== m_x2_i || x2_fu !== m_x2_f) begin n_fail++; $display("FAIL rnd_x2 cyc %0d got %0h/%0d want %0h/%0d", i, x2_instr, x2_fu, m_x2_i, m_x2_f); end
            tick();
        end
    endtask

    task automatic test_reset_midop();
        drive(1'b0, FU_NOP, 1'b0, 1'b0);
        tick();
        drive(1'b1, FU_ALU, 1'b0, 1'b0);
        tick();
        drive(1'b1, FU_IMU, 1'b0, 1'b0);
        tick();
        drive(1'b1, FU_SM, 1'b0, 1'b0);
        tick();
        n_checks++; if (pipeline_empty !== 1'b0 || retired_count === '0) begin n_fail++; $display("FAIL midop_pre got empty %0b cnt %0d want 0 nonzero", pipeline_empty, retired_count); end
        reset = 1'b0;
        #1;
        n_checks++; if (pipeline_empty !== 1'b1 || retired_count !== '0) begin n_fail++; $display("FAIL midop_reset got empty %0b cnt %0d want 1 0", pipeline_empty, retired_count); end
        n_checks++; if (issue_ready !== 1'b0 || x2_ret !== 3'd0 || dx1_ret !== 3'd0) begin n_fail++; $display("FAIL midop_outputs got ready %0b ret %0d/%0d want 0 0/0", issue_ready, dx1_ret, x2_ret); end
        model_clear();
        m_count = 0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        drive(1'b1, FU_ALU, 1'b0, 1'b0);
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL midop_ready_after got %0b want 1", issue_ready); end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_pair();
        test_imu_alu();
        test_back_to_back();
        test_stall();
        test_flush();
        test_wrap();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
